// File: rtl/svpcie_sim.sv
// svpcie_sim -- single-function PCIe BAR0 target model.
//
// Accepts decoded memory requests, serves them from a dword register file
// and returns completions in request order through a MAX_TAGS-deep FIFO.
// Malformed requests (misaligned, length other than one dword, or outside
// the BAR0 window) are Unsupported Requests and are reported on the
// cpl_err_ur_* pulses.
//
// Parameters:
//   MEM_BYTES  BAR0 window size in bytes (power of two, >= 64)
//   MAX_TAGS   outstanding non-posted requests / completion FIFO depth (>= 2)
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   rx_valid/rx_ready       request handshake
//   rx_write                1 = MWr (posted), 0 = MRd (non-posted)
//   rx_addr, rx_len         BAR0-relative byte address, length in dwords
//   rx_tag, rx_data         request tag, single-dword write payload
//   tx_valid/tx_ready       completion handshake
//   tx_tag, tx_status       original tag, 000 SC / 001 UR
//   tx_data                 read data (0 for UR)
//   cpl_err_ur_p/_np        one-cycle UR pulses, posted / non-posted
//
// Build option:
//   SVPCIE_UR_COUNT_EN      when defined, the last two dwords of BAR0 read
//                           back 16-bit saturating UR counters (posted at
//                           MEM_BYTES-8, non-posted at MEM_BYTES-4); writes
//                           there are accepted and ignored.

module svpcie_sim #(
    parameter int MEM_BYTES = 1024,
    parameter int MAX_TAGS  = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        rx_write,
    input  logic [31:0] rx_addr,
    input  logic [9:0]  rx_len,
    input  logic [7:0]  rx_tag,
    input  logic [31:0] rx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_tag,
    output logic [2:0]  tx_status,
    output logic [31:0] tx_data,
    output logic        cpl_err_ur_p,
    output logic        cpl_err_ur_np
);

    localparam int AW    = $clog2(MEM_BYTES);
    localparam int WORDS = MEM_BYTES / 4;
    localparam int PW    = $clog2(MAX_TAGS);
    localparam int CW    = $clog2(MAX_TAGS + 1);

    localparam logic [31:0]   MEM_LIM = 32'(MEM_BYTES);
    localparam logic [CW-1:0] FULL    = CW'(MAX_TAGS);
    localparam logic [2:0]    ST_SC   = 3'b000;
    localparam logic [2:0]    ST_UR   = 3'b001;

    // storage (not reset)
    logic [31:0] mem_q       [WORDS];
    logic [7:0]  fifo_tag_q  [MAX_TAGS];
    logic [2:0]  fifo_st_q   [MAX_TAGS];
    logic [31:0] fifo_data_q [MAX_TAGS];
    logic [31:0] rd_data_q;

    // control state
    logic          active_q;
    logic          s1_valid_q;
    logic          s1_ur_q;
    logic [7:0]    s1_tag_q;
    logic          ur_p_q;
    logic          ur_np_q;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    logic [AW-3:0] rx_idx;
    logic          req_ok;
    logic          accept;
    logic          push;
    logic          pop;
    logic [CW-1:0] occupancy;
    logic          rx_ctr_hit;
    logic [31:0]   push_data;

    assign rx_idx = rx_addr[AW-1:2];
    assign req_ok = (rx_addr[1:0] == 2'b00) && (rx_len == 10'd1) && (rx_addr < MEM_LIM);

    // A read in the memory-access stage already owns a FIFO slot, so it is
    // counted here; this keeps the FIFO from ever being pushed while full.
    assign occupancy = fifo_cnt_q + CW'(s1_valid_q);
    assign rx_ready  = active_q && (occupancy != FULL);
    assign accept    = rx_valid && rx_ready;

    assign tx_valid  = (fifo_cnt_q != '0);
    assign push      = s1_valid_q;
    assign pop       = tx_valid && tx_ready;

    assign tx_tag        = tx_valid ? fifo_tag_q[rd_ptr_q]  : '0;
    assign tx_status     = tx_valid ? fifo_st_q[rd_ptr_q]   : '0;
    assign tx_data       = tx_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign cpl_err_ur_p  = ur_p_q;
    assign cpl_err_ur_np = ur_np_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_TAGS - 1)) ? '0 : p + PW'(1);
    endfunction

`ifdef SVPCIE_UR_COUNT_EN
    localparam logic [AW-3:0] IDX_CNT_P  = (AW-2)'(WORDS - 2);
    localparam logic [AW-3:0] IDX_CNT_NP = (AW-2)'(WORDS - 1);

    logic [15:0] cnt_p_q;
    logic [15:0] cnt_np_q;
    logic        s1_ctr_sel_q;
    logic [15:0] s1_ctr_q;

    assign rx_ctr_hit = (rx_idx == IDX_CNT_P) || (rx_idx == IDX_CNT_NP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_p_q      <= '0;
            cnt_np_q     <= '0;
            s1_ctr_sel_q <= 1'b0;
            s1_ctr_q     <= '0;
        end else begin
            if (accept && !req_ok && rx_write && (cnt_p_q != 16'hFFFF))
                cnt_p_q <= cnt_p_q + 16'd1;
            if (accept && !req_ok && !rx_write && (cnt_np_q != 16'hFFFF))
                cnt_np_q <= cnt_np_q + 16'd1;
            if (accept && !rx_write) begin
                s1_ctr_sel_q <= rx_ctr_hit;
                s1_ctr_q     <= (rx_idx == IDX_CNT_NP) ? cnt_np_q : cnt_p_q;
            end
        end
    end

    assign push_data = s1_ur_q      ? '0 :
                       s1_ctr_sel_q ? {16'h0000, s1_ctr_q} : rd_data_q;
`else
    assign rx_ctr_hit = 1'b0;
    assign push_data  = s1_ur_q ? '0 : rd_data_q;
`endif

    always_comb begin
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q   <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_ur_q    <= 1'b0;
            s1_tag_q   <= '0;
            ur_p_q     <= 1'b0;
            ur_np_q    <= 1'b0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            active_q   <= 1'b1;
            s1_valid_q <= accept && !rx_write;
            if (accept && !rx_write) begin
                s1_ur_q  <= !req_ok;
                s1_tag_q <= rx_tag;
            end
            ur_p_q     <= accept && rx_write && !req_ok;
            ur_np_q    <= accept && !rx_write && !req_ok;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Register file and completion FIFO payload. A read captures the word at
    // acceptance, so a write accepted on any earlier cycle is always visible.
    always_ff @(posedge clk) begin
        if (accept && rx_write && req_ok && !rx_ctr_hit)
            mem_q[rx_idx] <= rx_data;
        if (accept && !rx_write)
            rd_data_q <= mem_q[rx_idx];
        if (push) begin
            fifo_tag_q[wr_ptr_q]  <= s1_tag_q;
            fifo_st_q[wr_ptr_q]   <= s1_ur_q ? ST_UR : ST_SC;
            fifo_data_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: tb/tb_svpcie_sim.sv
module tb_svpcie_sim;

    logic        clk;
    logic        reset_n;
    logic        rx_valid;
    logic        rx_ready;
    logic        rx_write;
    logic [31:0] rx_addr;
    logic [9:0]  rx_len;
    logic [7:0]  rx_tag;
    logic [31:0] rx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_tag;
    logic [2:0]  tx_status;
    logic [31:0] tx_data;
    logic        cpl_err_ur_p;
    logic        cpl_err_ur_np;

    int vec     = 0;
    int misc    = 0;
    int pop_cnt = 0;
    bit rand_rdy = 0;

    svpcie_sim #(.MEM_BYTES(1024), .MAX_TAGS(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_write     (rx_write),
        .rx_addr      (rx_addr),
        .rx_len       (rx_len),
        .rx_tag       (rx_tag),
        .rx_data      (rx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_tag       (tx_tag),
        .tx_status    (tx_status),
        .tx_data      (tx_data),
        .cpl_err_ur_p (cpl_err_ur_p),
        .cpl_err_ur_np(cpl_err_ur_np)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            misc++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0]  tag;
        logic [2:0]  st;
        logic [31:0] data;
    } cpl_t;

    cpl_t        exp_q[$];
    logic [31:0] model_mem [256];
    bit          exp_urp, exp_urnp, hold_v;
    cpl_t        hold_c;

    function automatic bit model_ok(input logic [31:0] a, input logic [9:0] l);
        return (a % 4 == 0) && (l == 1) && (a < 1024);
    endfunction

    // Samples 2 time units before each rising edge: checks pulses, hold
    // stability and popped completions, then applies any request that will
    // be accepted at the coming edge to the model.
    always @(negedge clk) begin
        #3;
        if (!reset_n) begin
            exp_q.delete();
            exp_urp  = 0;
            exp_urnp = 0;
            hold_v   = 0;
        end else begin
            check("ur_p pulse", cpl_err_ur_p, exp_urp);
            check("ur_np pulse", cpl_err_ur_np, exp_urnp);
            if (hold_v) begin
                check("hold tx_valid", tx_valid, 1);
                check("hold tx payload", {tx_tag, tx_status, tx_data}, hold_c);
            end
            if (tx_valid && tx_ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    vec++;
                    misc++;
                    $display("FAIL unexpected completion: got tag %h status %h data %h, expected none",
                             tx_tag, tx_status, tx_data);
                end else begin
                    check($sformatf("completion %0d", pop_cnt), {tx_tag, tx_status, tx_data},
                          exp_q.pop_front());
                end
            end
            hold_v   = tx_valid && !tx_ready;
            hold_c   = {tx_tag, tx_status, tx_data};
            exp_urp  = 0;
            exp_urnp = 0;
            if (rx_valid && rx_ready) begin
                if (rx_write) begin
                    if (model_ok(rx_addr, rx_len)) model_mem[int'(rx_addr / 4)] = rx_data;
                    else exp_urp = 1;
                end else begin
                    if (model_ok(rx_addr, rx_len))
                        exp_q.push_back({rx_tag, 3'd0, model_mem[int'(rx_addr / 4)]});
                    else begin
                        exp_q.push_back({rx_tag, 3'd1, 32'd0});
                        exp_urnp = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) if (rand_rdy) tx_ready = ($urandom_range(0, 3) != 0);

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    // Called at a falling edge; returns at the falling edge after acceptance
    // with rx_valid still asserted.
    task automatic do_req(input bit w, input logic [31:0] a, input logic [9:0] l,
                          input logic [7:0] t, input logic [31:0] d, output int waited);
        rx_valid = 1; rx_write = w; rx_addr = a; rx_len = l; rx_tag = t; rx_data = d;
        waited = 0;
        while (!rx_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!rx_ready) begin
            check("request accept timeout", 0, 1);
            rx_valid = 0;
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int n = 0;
        tx_ready = 1;
        while ((exp_q.size() != 0 || tx_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain completes", (exp_q.size() == 0) && !tx_valid, 1);
    endtask

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [9:0]  l;
        logic [7:0]  t;
        logic [31:0] d;
        logic [2:0]  st;
        logic [31:0] rd;
        bit          up;
        bit          unp;
    } vec_t;

    vec_t tbl[14];
    int   w;
    int   base;
    logic [31:0] ra;
    logic [9:0]  rl;
    int   k;

    initial begin
        tbl[0]  = '{1, 32'd14,         10'd1, 8'd0,  32'h0000_1337, 3'd0, 32'd0,          1, 0};
        tbl[1]  = '{0, 32'd14,         10'd1, 8'd5,  32'd0,         3'd1, 32'd0,          0, 1};
        tbl[2]  = '{1, 32'd512,        10'd1, 8'd0,  32'hdead_beef, 3'd0, 32'd0,          0, 0};
        tbl[3]  = '{0, 32'd512,        10'd1, 8'd6,  32'd0,         3'd0, 32'hdead_beef,  0, 0};
        tbl[4]  = '{1, 32'h40,         10'd2, 8'd0,  32'd1,         3'd0, 32'd0,          1, 0};
        tbl[5]  = '{0, 32'h40,         10'd0, 8'd7,  32'd0,         3'd1, 32'd0,          0, 1};
        tbl[6]  = '{1, 32'd1020,       10'd1, 8'd0,  32'h0bad_0001, 3'd0, 32'd0,          0, 0};
        tbl[7]  = '{0, 32'd1020,       10'd1, 8'd8,  32'd0,         3'd0, 32'h0bad_0001,  0, 0};
        tbl[8]  = '{1, 32'd1024,       10'd1, 8'd0,  32'h5555_5555, 3'd0, 32'd0,          1, 0};
        tbl[9]  = '{0, 32'hFFFF_FFFC,  10'd1, 8'd9,  32'd0,         3'd1, 32'd0,          0, 1};
        tbl[10] = '{1, 32'h40,         10'd1, 8'd0,  32'ha5a5_a5a5, 3'd0, 32'd0,          0, 0};
        tbl[11] = '{1, 32'h40,         10'd3, 8'd0,  32'd0,         3'd0, 32'd0,          1, 0};
        tbl[12] = '{0, 32'h40,         10'd1, 8'd11, 32'd0,         3'd0, 32'ha5a5_a5a5,  0, 0};
        tbl[13] = '{0, 32'h42,         10'd1, 8'd12, 32'd0,         3'd1, 32'd0,          0, 1};

        reset_n = 0; rx_valid = 0; rx_write = 0; rx_addr = 0; rx_len = 0;
        rx_tag = 0; rx_data = 0; tx_ready = 0;

        // reset state
        @(negedge clk);
        check("reset outputs",
              {rx_ready, tx_valid, tx_tag, tx_status, tx_data, cpl_err_ur_p, cpl_err_ur_np}, 0);
        @(negedge clk);
        reset_n = 1;
        check("rx_ready before first edge", rx_ready, 0);
        @(negedge clk);
        check("rx_ready out of reset", rx_ready, 1);

        // table-driven single requests with exact latency
        tx_ready = 1;
        for (int i = 0; i < 14; i++) begin
            do_req(tbl[i].w, tbl[i].a, tbl[i].l, tbl[i].t, tbl[i].d, w);
            rx_valid = 0;
            check($sformatf("tbl%0d ur pulses", i), {cpl_err_ur_p, cpl_err_ur_np}, {tbl[i].up, tbl[i].unp});
            check($sformatf("tbl%0d no early cpl", i), tx_valid, 0);
            @(negedge clk);
            if (tbl[i].w)
                check($sformatf("tbl%0d no completion", i), tx_valid, 0);
            else
                check($sformatf("tbl%0d completion", i), {tx_valid, tx_tag, tx_status, tx_data},
                      {1'b1, tbl[i].t, tbl[i].st, tbl[i].rd});
            check($sformatf("tbl%0d pulse width", i), {cpl_err_ur_p, cpl_err_ur_np}, 0);
            @(negedge clk);
        end

        // 31 writes, then 31 reads held back, then in-order release
        tx_ready = 0;
        for (int i = 0; i <= 30; i++) do_req(1, 32'(i * 4), 10'd1, 8'd0, 32'(i * 4), w);
        base = pop_cnt;
        for (int i = 0; i <= 30; i++) begin
            do_req(0, 32'(i * 4), 10'd1, 8'(i), 32'd0, w);
            check($sformatf("burst read %0d no stall", i), w, 0);
        end
        rx_valid = 0;
        @(negedge clk);
        check("burst head held", {tx_valid, tx_tag, tx_status, tx_data}, {1'b1, 8'd0, 3'd0, 32'd0});
        drain();
        check("burst pop count", pop_cnt - base, 31);

        // backpressure at MAX_TAGS
        tx_ready = 0;
        base = pop_cnt;
        for (int i = 0; i < 32; i++) begin
            do_req(0, 32'((i % 31) * 4), 10'd1, 8'(100 + i), 32'd0, w);
            check($sformatf("fill read %0d no stall", i), w, 0);
        end
        rx_valid = 0;
        check("rx_ready low when full", rx_ready, 0);
        rx_valid = 1; rx_write = 0; rx_addr = 32'd20; rx_len = 10'd1; rx_tag = 8'd200;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("33rd read blocked", rx_ready, 0);
        end
        tx_ready = 1;
        @(negedge clk);
        tx_ready = 0;
        check("rx_ready after one pop", rx_ready, 1);
        @(negedge clk);
        rx_valid = 0;
        check("full again after 33rd", rx_ready, 0);
        drain();
        check("backpressure pop count", pop_cnt - base, 33);

        // reset with completions queued
        tx_ready = 0;
        for (int i = 0; i < 10; i++) do_req(0, 32'd0, 10'd1, 8'(50 + i), 32'd0, w);
        rx_valid = 0;
        @(negedge clk);
        @(negedge clk);
        check("queued before reset", tx_valid, 1);
        #2 reset_n = 0;
        #1 check("async reset outputs",
                 {rx_ready, tx_valid, tx_tag, tx_status, tx_data, cpl_err_ur_p, cpl_err_ur_np}, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        check("empty after reset", {rx_ready, tx_valid}, 2'b10);
        tx_ready = 1;
        do_req(0, 32'h40, 10'd1, 8'd77, 32'd0, w);
        rx_valid = 0;
        check("post-reset no early cpl", tx_valid, 0);
        @(negedge clk);
        check("post-reset completion", {tx_valid, tx_tag, tx_status, tx_data},
              {1'b1, 8'd77, 3'd0, 32'd64});
        @(negedge clk);
        check("no stale completions", tx_valid, 0);

        // randomized traffic against the model
        rand_rdy = 1;
        for (int i = 0; i < 256; i++) do_req(1, 32'(i * 4), 10'd1, 8'd0, $urandom, w);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                rx_valid = 0;
                @(negedge clk);
            end
            ra = 32'($urandom_range(0, 255) * 4);
            rl = 10'd1;
            k  = int'($urandom_range(0, 9));
            if (k == 7) ra = ra | 32'($urandom_range(1, 3));
            else if (k == 8) rl = ($urandom_range(0, 1) == 0) ? 10'd0 : 10'($urandom_range(2, 1023));
            else if (k == 9) ra = 32'd1024 + 32'($urandom_range(0, 100000) * 4);
            do_req($urandom_range(0, 1) == 1, ra, rl, 8'(i), $urandom, w);
        end
        rx_valid = 0;
        rand_rdy = 0;
        @(negedge clk);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec, misc);
        $finish;
    end

endmodule
